// File: rtl/id_ex_pipeline_register_pkg.sv
// Shared Decode->Execute pipeline types: control/data bundle, ALU op encodings, bubble constants.
package id_ex_pipeline_register_pkg;

  localparam int ID_EX_XLEN       = 32;
  localparam int ID_EX_REG_ADDR_W = 5;

  localparam logic [1:0] ALU_OP_LOAD_STORE = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH     = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE      = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE      = 2'b11;

  typedef struct packed {
    logic       branchEnable;
    logic       memoryReadEnable;
    logic       memoryWriteEnable;
    logic       registerWriteEnable;
    logic       immediateEnable;
    logic       memoryOrAlu;
    logic [1:0] aluOperation;
  } idExControl_t;

  typedef struct packed {
    logic                        valid;
    idExControl_t                ctrl;
    logic [ID_EX_XLEN-1:0]       pc;
    logic [ID_EX_XLEN-1:0]       rs1Data;
    logic [ID_EX_XLEN-1:0]       rs2Data;
    logic [ID_EX_XLEN-1:0]       immediate;
    logic [ID_EX_REG_ADDR_W-1:0] rs1Addr;
    logic [ID_EX_REG_ADDR_W-1:0] rs2Addr;
    logic [ID_EX_REG_ADDR_W-1:0] rdAddr;
    logic [2:0]                  funct3;
    logic                        funct7b5;
  } idExBundle_t;

  localparam idExControl_t CTRL_BUBBLE = '0;
  localparam idExBundle_t  BUBBLE      = '0;

endpackage

// File: rtl/id_ex_pipeline_register_if.sv
// Decode-side inputs and Execute-side registered outputs of the ID/EX stage.
interface id_ex_pipeline_register_if
  import id_ex_pipeline_register_pkg::*;
#(
  parameter int XLEN       = ID_EX_XLEN,
  parameter int REG_ADDR_W = ID_EX_REG_ADDR_W
);
  logic                  validIn,  validOut;
  logic [XLEN-1:0]       pcIn,        pcOut;
  logic [XLEN-1:0]       rs1DataIn,   rs1DataOut;
  logic [XLEN-1:0]       rs2DataIn,   rs2DataOut;
  logic [XLEN-1:0]       immediateIn, immediateOut;
  logic [REG_ADDR_W-1:0] rs1AddrIn,   rs1AddrOut;
  logic [REG_ADDR_W-1:0] rs2AddrIn,   rs2AddrOut;
  logic [REG_ADDR_W-1:0] rdAddrIn,    rdAddrOut;
  logic [2:0]            funct3In,    funct3Out;
  logic                  funct7b5In,  funct7b5Out;
  logic                  branchEnableIn,        branchEnableOut;
  logic                  memoryReadEnableIn,    memoryReadEnableOut;
  logic                  memoryWriteEnableIn,   memoryWriteEnableOut;
  logic                  registerWriteEnableIn, registerWriteEnableOut;
  logic                  immediateEnableIn,     immediateEnableOut;
  logic                  memoryOrAluIn,         memoryOrAluOut;
  logic [1:0]            aluOperationIn,        aluOperationOut;

  modport master (
    output validIn, pcIn, rs1DataIn, rs2DataIn, immediateIn, rs1AddrIn, rs2AddrIn, rdAddrIn,
           funct3In, funct7b5In, branchEnableIn, memoryReadEnableIn, memoryWriteEnableIn,
           registerWriteEnableIn, immediateEnableIn, memoryOrAluIn, aluOperationIn,
    input  validOut, pcOut, rs1DataOut, rs2DataOut, immediateOut, rs1AddrOut, rs2AddrOut, rdAddrOut,
           funct3Out, funct7b5Out, branchEnableOut, memoryReadEnableOut, memoryWriteEnableOut,
           registerWriteEnableOut, immediateEnableOut, memoryOrAluOut, aluOperationOut
  );

  modport slave (
    input  validIn, pcIn, rs1DataIn, rs2DataIn, immediateIn, rs1AddrIn, rs2AddrIn, rdAddrIn,
           funct3In, funct7b5In, branchEnableIn, memoryReadEnableIn, memoryWriteEnableIn,
           registerWriteEnableIn, immediateEnableIn, memoryOrAluIn, aluOperationIn,
    output validOut, pcOut, rs1DataOut, rs2DataOut, immediateOut, rs1AddrOut, rs2AddrOut, rdAddrOut,
           funct3Out, funct7b5Out, branchEnableOut, memoryReadEnableOut, memoryWriteEnableOut,
           registerWriteEnableOut, immediateEnableOut, memoryOrAluOut, aluOperationOut
  );
endinterface

// File: rtl/id_ex_pipeline_register_hazard.sv
// load_use_hazard_detector: flags a consumer in Decode of a load currently sitting in ID/EX.
module load_use_hazard_detector #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  validIn,
  input  logic                  validOut,
  input  logic                  memoryReadEnableOut,
  input  logic [REG_ADDR_W-1:0] rdAddrOut,
  input  logic [REG_ADDR_W-1:0] rs1AddrIn,
  input  logic [REG_ADDR_W-1:0] rs2AddrIn,
  input  logic                  immediateEnableIn,
  input  logic                  memoryWriteEnableIn,
  input  logic                  flush,
  input  logic                  externalStall,
  output logic                  hazardStall
);
  logic uses_rs2;
  logic addr_match;

  // Stores read rs2 as store data even though they also carry an immediate.
  assign uses_rs2   = ~immediateEnableIn | memoryWriteEnableIn;
  assign addr_match = (rdAddrOut == rs1AddrIn) | (uses_rs2 & (rdAddrOut == rs2AddrIn));

  assign hazardStall = validIn & validOut & memoryReadEnableOut & (rdAddrOut != '0) & addr_match
                     & ~flush & ~externalStall;
endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with load-use bubble insertion, flush and external stall.
// Optional perf counters enabled by defining ID_EX_PERF_COUNTERS_EN.
module id_ex_pipeline_register
  import id_ex_pipeline_register_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        externalStall,
  id_ex_pipeline_register_if.slave    bus,
  output logic                        hazardStall,
  output logic [31:0]                 bubbleCount,
  output logic [31:0]                 flushCount
);
  idExBundle_t id_ex_d, id_ex_q, load_bundle;

  load_use_hazard_detector #(.REG_ADDR_W(ID_EX_REG_ADDR_W)) u_hazard (
    .validIn             (bus.validIn),
    .validOut            (id_ex_q.valid),
    .memoryReadEnableOut (id_ex_q.ctrl.memoryReadEnable),
    .rdAddrOut           (id_ex_q.rdAddr),
    .rs1AddrIn           (bus.rs1AddrIn),
    .rs2AddrIn           (bus.rs2AddrIn),
    .immediateEnableIn   (bus.immediateEnableIn),
    .memoryWriteEnableIn (bus.memoryWriteEnableIn),
    .flush               (flush),
    .externalStall       (externalStall),
    .hazardStall         (hazardStall)
  );

  always_comb begin
    load_bundle                          = BUBBLE;
    load_bundle.valid                    = bus.validIn;
    load_bundle.pc                       = bus.pcIn;
    load_bundle.rs1Data                  = bus.rs1DataIn;
    load_bundle.rs2Data                  = bus.rs2DataIn;
    load_bundle.immediate                = bus.immediateIn;
    load_bundle.rs1Addr                  = bus.rs1AddrIn;
    load_bundle.rs2Addr                  = bus.rs2AddrIn;
    load_bundle.rdAddr                   = bus.rdAddrIn;
    load_bundle.funct3                   = bus.funct3In;
    load_bundle.funct7b5                 = bus.funct7b5In;
    load_bundle.ctrl.branchEnable        = bus.branchEnableIn;
    load_bundle.ctrl.memoryReadEnable    = bus.memoryReadEnableIn;
    load_bundle.ctrl.memoryWriteEnable   = bus.memoryWriteEnableIn;
    load_bundle.ctrl.registerWriteEnable = bus.registerWriteEnableIn;
    load_bundle.ctrl.immediateEnable     = bus.immediateEnableIn;
    load_bundle.ctrl.memoryOrAlu         = bus.memoryOrAluIn;
    load_bundle.ctrl.aluOperation        = bus.aluOperationIn;
    // Execute must never act on a non-instruction, whatever Decode drives.
    if (!bus.validIn) load_bundle.ctrl = CTRL_BUBBLE;
  end

  always_comb begin
    id_ex_d = id_ex_q;
    if (flush)              id_ex_d = BUBBLE;
    else if (externalStall) id_ex_d = id_ex_q;
    else if (hazardStall)   id_ex_d = BUBBLE;
    else                    id_ex_d = load_bundle;
  end

  always_ff @(posedge clock) begin
    if (reset) id_ex_q <= BUBBLE;
    else       id_ex_q <= id_ex_d;
  end

  assign bus.validOut               = id_ex_q.valid;
  assign bus.pcOut                  = id_ex_q.pc;
  assign bus.rs1DataOut             = id_ex_q.rs1Data;
  assign bus.rs2DataOut             = id_ex_q.rs2Data;
  assign bus.immediateOut           = id_ex_q.immediate;
  assign bus.rs1AddrOut             = id_ex_q.rs1Addr;
  assign bus.rs2AddrOut             = id_ex_q.rs2Addr;
  assign bus.rdAddrOut              = id_ex_q.rdAddr;
  assign bus.funct3Out              = id_ex_q.funct3;
  assign bus.funct7b5Out            = id_ex_q.funct7b5;
  assign bus.branchEnableOut        = id_ex_q.ctrl.branchEnable;
  assign bus.memoryReadEnableOut    = id_ex_q.ctrl.memoryReadEnable;
  assign bus.memoryWriteEnableOut   = id_ex_q.ctrl.memoryWriteEnable;
  assign bus.registerWriteEnableOut = id_ex_q.ctrl.registerWriteEnable;
  assign bus.immediateEnableOut     = id_ex_q.ctrl.immediateEnable;
  assign bus.memoryOrAluOut         = id_ex_q.ctrl.memoryOrAlu;
  assign bus.aluOperationOut        = id_ex_q.ctrl.aluOperation;

`ifdef ID_EX_PERF_COUNTERS_EN
  logic [31:0] bubble_count_d, bubble_count_q;
  logic [31:0] flush_count_d,  flush_count_q;

  // hazardStall is already masked by flush/externalStall, so it marks the hazard path exactly.
  always_comb begin
    bubble_count_d = bubble_count_q;
    flush_count_d  = flush_count_q;
    if (flush) begin
      if (bus.validIn) flush_count_d = flush_count_q + 32'd1;
    end else if (hazardStall) begin
      bubble_count_d = bubble_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bubble_count_q <= '0;
      flush_count_q  <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bubbleCount = bubble_count_q;
  assign flushCount  = flush_count_q;
`else
  assign bubbleCount = 32'h0;
  assign flushCount  = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed load-use/flush/stall scenarios followed by random traffic against a behavioural model.
module tb_id_ex_pipeline_register;
  logic        clock = 1'b0;
  logic        reset, flush, externalStall;
  logic        hazardStall;
  logic [31:0] bubbleCount, flushCount;

  id_ex_pipeline_register_if bus ();

  id_ex_pipeline_register dut (
    .clock(clock), .reset(reset), .flush(flush), .externalStall(externalStall),
    .bus(bus), .hazardStall(hazardStall), .bubbleCount(bubbleCount), .flushCount(flushCount)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;

  // Expected contents of the stage as seen by Execute.
  logic        m_valid, m_br, m_mr, m_mw, m_rw, m_ie, m_moa, m_f7;
  logic [1:0]  m_aop;
  logic [2:0]  m_f3;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [31:0] m_bub, m_fl;

  logic        obs_haz, obs_valid, obs_rw, exp_haz;
  logic [31:0] obs_pc, obs_bub, obs_fl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef ID_EX_PERF_COUNTERS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic m_clear();
    {m_valid, m_br, m_mr, m_mw, m_rw, m_ie, m_moa, m_f7, m_aop, m_f3} = '0;
    {m_rs1a, m_rs2a, m_rd, m_pc, m_rs1d, m_rs2d, m_imm} = '0;
  endtask

  // Load-use rule: a load in Execute whose rd (not x0) is read by the instruction in Decode.
  function automatic logic model_haz();
    logic reads_rs2;
    if (flush || externalStall) return 1'b0;
    reads_rs2 = !bus.immediateEnableIn || bus.memoryWriteEnableIn;
    return bus.validIn && m_valid && m_mr && (m_rd != 5'd0) &&
           ((m_rd == bus.rs1AddrIn) || (reads_rs2 && m_rd == bus.rs2AddrIn));
  endfunction

  task automatic model_edge(input logic haz);
    if (reset) begin
      m_clear(); m_bub = 0; m_fl = 0;
    end else if (flush) begin
      m_clear();
      if (bus.validIn) m_fl = m_fl + 1;
    end else if (externalStall) begin
      // nothing moves
    end else if (haz) begin
      m_clear(); m_bub = m_bub + 1;
    end else begin
      m_valid = bus.validIn; m_pc = bus.pcIn; m_rs1d = bus.rs1DataIn; m_rs2d = bus.rs2DataIn;
      m_imm = bus.immediateIn; m_rs1a = bus.rs1AddrIn; m_rs2a = bus.rs2AddrIn; m_rd = bus.rdAddrIn;
      m_f3 = bus.funct3In; m_f7 = bus.funct7b5In;
      if (bus.validIn) begin
        m_br = bus.branchEnableIn; m_mr = bus.memoryReadEnableIn; m_mw = bus.memoryWriteEnableIn;
        m_rw = bus.registerWriteEnableIn; m_ie = bus.immediateEnableIn;
        m_moa = bus.memoryOrAluIn; m_aop = bus.aluOperationIn;
      end else begin
        {m_br, m_mr, m_mw, m_rw, m_ie, m_moa, m_aop} = '0;
      end
    end
  endtask

  task automatic compare_all();
    chk("validOut", {31'd0, bus.validOut}, {31'd0, m_valid});
    chk("pcOut", bus.pcOut, m_pc);
    chk("rs1DataOut", bus.rs1DataOut, m_rs1d);
    chk("rs2DataOut", bus.rs2DataOut, m_rs2d);
    chk("immediateOut", bus.immediateOut, m_imm);
    chk("addrs", {17'd0, bus.rs1AddrOut, bus.rs2AddrOut, bus.rdAddrOut}, {17'd0, m_rs1a, m_rs2a, m_rd});
    chk("funct", {28'd0, bus.funct3Out, bus.funct7b5Out}, {28'd0, m_f3, m_f7});
    chk("control", {24'd0, bus.branchEnableOut, bus.memoryReadEnableOut, bus.memoryWriteEnableOut,
                    bus.registerWriteEnableOut, bus.immediateEnableOut, bus.memoryOrAluOut,
                    bus.aluOperationOut},
                   {24'd0, m_br, m_mr, m_mw, m_rw, m_ie, m_moa, m_aop});
    chk("bubbleCount", bubbleCount, exp_cnt(m_bub));
    chk("flushCount", flushCount, exp_cnt(m_fl));
  endtask

  // One clock: check state at negedge, then advance the model at the edge.
  task automatic step(input logic rst);
    reset = rst;
    @(negedge clock);
    compare_all();
    exp_haz = model_haz();
    chk("hazardStall", {31'd0, hazardStall}, {31'd0, exp_haz});
    obs_haz = hazardStall; obs_valid = bus.validOut; obs_rw = bus.registerWriteEnableOut;
    obs_pc = bus.pcOut; obs_bub = bubbleCount; obs_fl = flushCount;
    @(posedge clock);
    model_edge(exp_haz);
    #1;
  endtask

  // kind: 0 R-type, 1 load, 2 I-type ALU, 3 store, 4 branch
  task automatic set_instr(input int kind, input logic v, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] pc);
    bus.validIn = v; bus.pcIn = pc; bus.rdAddrIn = rd; bus.rs1AddrIn = rs1; bus.rs2AddrIn = rs2;
    bus.rs1DataIn = $urandom; bus.rs2DataIn = $urandom; bus.immediateIn = $urandom;
    bus.funct3In = 3'($urandom); bus.funct7b5In = 1'($urandom);
    {bus.branchEnableIn, bus.memoryReadEnableIn, bus.memoryWriteEnableIn, bus.registerWriteEnableIn,
     bus.immediateEnableIn, bus.memoryOrAluIn, bus.aluOperationIn} = '0;
    case (kind)
      0: begin bus.registerWriteEnableIn = 1; bus.aluOperationIn = 2'b10; end
      1: begin bus.memoryReadEnableIn = 1; bus.registerWriteEnableIn = 1;
               bus.immediateEnableIn = 1; bus.memoryOrAluIn = 1; end
      2: begin bus.registerWriteEnableIn = 1; bus.immediateEnableIn = 1; bus.aluOperationIn = 2'b11; end
      3: begin bus.memoryWriteEnableIn = 1; bus.immediateEnableIn = 1; end
      default: begin bus.branchEnableIn = 1; bus.aluOperationIn = 2'b01; end
    endcase
  endtask

  task automatic nop();
    set_instr(0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
  endtask

  initial begin
    logic hold;
    flush = 0; externalStall = 0; reset = 1;
    m_clear(); m_bub = 0; m_fl = 0;

    // 1: reset with random inputs
    set_instr(1, 1'b1, 5'd9, 5'd3, 5'd4, $urandom); step(1'b1);
    set_instr(0, 1'b1, 5'd7, 5'd9, 5'd9, $urandom); step(1'b1);
    // 2: add x3,x1,x2
    set_instr(0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h100); step(1'b0);
    chk("t1_validOut", {31'd0, obs_valid}, 32'd0);
    chk("t1_hazard", {31'd0, obs_haz}, 32'd0);
    nop(); step(1'b0);
    chk("t2_validOut", {31'd0, obs_valid}, 32'd1);
    chk("t2_regWrite", {31'd0, obs_rw}, 32'd1);
    chk("t2_pc", obs_pc, 32'h100);
    // 3: lw x5,0(x1); add x6,x5,x7
    set_instr(1, 1'b1, 5'd5, 5'd1, 5'd0, 32'h104); step(1'b0);
    set_instr(0, 1'b1, 5'd6, 5'd5, 5'd7, 32'h108); step(1'b0);
    chk("t3_hazard", {31'd0, obs_haz}, 32'd1);
    step(1'b0);
    chk("t3_bubble_valid", {31'd0, obs_valid}, 32'd0);
    chk("t3_no_second_stall", {31'd0, obs_haz}, 32'd0);
    nop(); step(1'b0);
    chk("t3_add_enters", obs_pc, 32'h108);
    chk("t3_bubbleCount", obs_bub, exp_cnt(32'd1));
    // 4: rd=x0 and I-type rs2 field never stall
    set_instr(1, 1'b1, 5'd0, 5'd1, 5'd0, 32'h10c); step(1'b0);
    set_instr(0, 1'b1, 5'd6, 5'd0, 5'd7, 32'h110); step(1'b0);
    chk("t4_x0_hazard", {31'd0, obs_haz}, 32'd0);
    set_instr(1, 1'b1, 5'd5, 5'd1, 5'd0, 32'h114); step(1'b0);
    set_instr(2, 1'b1, 5'd6, 5'd1, 5'd5, 32'h118); step(1'b0);
    chk("t4_addi_hazard", {31'd0, obs_haz}, 32'd0);
    // 5: flush coincident with a hazard
    set_instr(1, 1'b1, 5'd5, 5'd1, 5'd0, 32'h11c); step(1'b0);
    set_instr(0, 1'b1, 5'd6, 5'd5, 5'd7, 32'h120); flush = 1; step(1'b0);
    chk("t5_hazard_masked", {31'd0, obs_haz}, 32'd0);
    flush = 0; nop(); step(1'b0);
    chk("t5_bubble_valid", {31'd0, obs_valid}, 32'd0);
    chk("t5_flushCount", obs_fl, exp_cnt(32'd1));
    // 6: external stall for 3 cycles
    set_instr(0, 1'b1, 5'd8, 5'd2, 5'd3, 32'h200); step(1'b0);
    externalStall = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(int'($urandom_range(0, 4)), 1'b1, 5'd9, 5'd1, 5'd2, $urandom);
      step(1'b0);
      chk("t6_frozen_pc", obs_pc, 32'h200);
    end
    externalStall = 0;
    set_instr(2, 1'b1, 5'd10, 5'd4, 5'd0, 32'h300); step(1'b0);
    chk("t6_still_held", obs_pc, 32'h200);
    nop(); step(1'b0);
    chk("t6_resumed", obs_pc, 32'h300);

    // Random traffic; Decode re-presents an instruction it was told to hold.
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold)
        set_instr(int'($urandom_range(0, 4)), 1'($urandom_range(0, 5) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
      flush         = ($urandom_range(0, 9) == 0);
      externalStall = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 59) == 0);
      hold = exp_haz || externalStall;
    end
    flush = 0; externalStall = 0; nop(); step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
